// File: rtl/ps2_key_events.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix decoder, modifier/Caps tracking, event FIFO.
// Optional frame watchdog enabled by defining PS2_TIMEOUT_EN.
module ps2_key_events #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [7:0]                   ev_code,
  output logic                         ev_ext,
  output logic                         ev_break,
  output logic [$clog2(FIFO_DEPTH):0]  ev_level,
  output logic                         mod_shift,
  output logic                         mod_ctrl,
  output logic                         mod_alt,
  output logic                         caps_lock,
  output logic                         overflow,
  input  logic                         ovf_clr,
  output logic [7:0]                   err_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic        clk_q, data_q, sample;
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;
  logic [10:0] frame_c;
  logic        frame_ok_c, err_inc_c, timeout_c;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [1:0]  state, state_n;
  logic        emit_c, emit_ext_c, emit_brk_c;
  logic [5:0]  held, held_n;
  logic        caps_held, caps_held_n, caps_n;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_c, push_c, drop_c, full_c;
  logic [LW-1:0] level_n;

  // Pin synchronisers and falling-edge strobe on the PS/2 clock
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_q    <= 1'b1;
      data_q   <= 1'b1;
      sample   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_q    <= clk_sync[SYNC_STAGES-1];
      data_q   <= dat_sync[SYNC_STAGES-1];
      sample   <= clk_q & ~clk_sync[SYNC_STAGES-1];
    end
  end

  assign frame_c    = {data_q, shreg};
  assign frame_ok_c = ~frame_c[0] & frame_c[10] & (^frame_c[9:1]);
  assign err_inc_c  = (sample && bit_cnt == 4'd10 && !frame_ok_c) || timeout_c;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  // Watchdog: abandons a frame whose bits stop arriving
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) idle_cnt <= '0;
    else if (sample || bit_cnt == 4'd0 || timeout_c) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + TW'(1);
  end

  assign timeout_c = (bit_cnt != 4'd0) && !sample && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  // Deserialiser: start, 8 data LSB first, odd parity, stop
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt  <= 4'd0;
      shreg    <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= 8'd0;
      err_cnt  <= 8'd0;
    end else begin
      rx_valid <= 1'b0;
      if (sample) begin
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok_c) begin
            rx_valid <= 1'b1;
            rx_byte  <= frame_c[8:1];
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {data_q, shreg[9:1]};
        end
      end else if (timeout_c) begin
        bit_cnt <= 4'd0;
      end
      if (err_inc_c && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else if (timeout_c) state <= ST_IDLE;
    else state <= state_n;
  end

  // Prefix decoder: E0 always resynchronises, F0 marks a release
  always_comb begin
    state_n    = state;
    emit_c     = 1'b0;
    emit_ext_c = (state == ST_EXT) || (state == ST_EXT_BRK);
    emit_brk_c = (state == ST_BRK) || (state == ST_EXT_BRK);
    if (rx_valid) begin
      if (rx_byte == 8'hE0) begin
        state_n = ST_EXT;
      end else if (rx_byte == 8'hF0) begin
        case (state)
          ST_IDLE: state_n = ST_BRK;
          ST_EXT:  state_n = ST_EXT_BRK;
          default: state_n = state;
        endcase
      end else begin
        emit_c  = 1'b1;
        state_n = ST_IDLE;
      end
    end
  end

  // Held keys: [0] L shift, [1] R shift, [2] L ctrl, [3] R ctrl, [4] L alt, [5] R alt
  always_comb begin
    held_n      = held;
    caps_n      = caps_lock;
    caps_held_n = caps_held;
    if (emit_c) begin
      if (!emit_ext_c && rx_byte == 8'h12) held_n[0] = ~emit_brk_c;
      if (!emit_ext_c && rx_byte == 8'h59) held_n[1] = ~emit_brk_c;
      if (rx_byte == 8'h14) held_n[3'd2 + 3'(emit_ext_c)] = ~emit_brk_c;
      if (rx_byte == 8'h11) held_n[3'd4 + 3'(emit_ext_c)] = ~emit_brk_c;
      if (rx_byte == 8'h58) begin
        if (emit_brk_c) begin
          caps_held_n = 1'b0;
        end else if (!caps_held) begin
          caps_n      = ~caps_lock;
          caps_held_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      held      <= '0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
      mod_shift <= 1'b0;
      mod_ctrl  <= 1'b0;
      mod_alt   <= 1'b0;
    end else begin
      held      <= held_n;
      caps_held <= caps_held_n;
      caps_lock <= caps_n;
      mod_shift <= held_n[0] | held_n[1];
      mod_ctrl  <= held_n[2] | held_n[3];
      mod_alt   <= held_n[4] | held_n[5];
    end
  end

  assign pop_c   = ev_valid & ev_ready;
  assign full_c  = (ev_level == LW'(FIFO_DEPTH));
  assign push_c  = emit_c & (~full_c | pop_c);
  assign drop_c  = emit_c & full_c & ~pop_c;
  assign level_n = ev_level + LW'(push_c) - LW'(pop_c);

  // First-word fall-through event FIFO
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_level <= '0;
      ev_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= {emit_ext_c, emit_brk_c, rx_byte};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      ev_level <= level_n;
      ev_valid <= (level_n != '0);
      if (drop_c) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign {ev_ext, ev_break, ev_code} = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_key_events.sv
// Randomised scoreboard bench for ps2_key_events against a key-event reference model.
module tb_ps2_key_events;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 200;
  localparam int unsigned HALF  = 8;

  logic       clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       ev_ready = 1'b0, ovf_clr = 1'b0;
  logic       ev_valid, ev_ext, ev_break, mod_shift, mod_ctrl, mod_alt, caps_lock, overflow;
  logic [7:0] ev_code, err_cnt;
  logic [3:0] ev_level;

  ps2_key_events #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_level(ev_level), .mod_shift(mod_shift), .mod_ctrl(mod_ctrl),
    .mod_alt(mod_alt), .caps_lock(caps_lock), .overflow(overflow), .ovf_clr(ovf_clr),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int rdy_mode = 1;            // 0 random, 1 hold off, 2 always ready
  logic [9:0] exp_q[$];

  // Reference model: prefix flags, set of held keys indexed {ext,code}
  bit m_ext, m_brk, m_caps, m_caps_held, m_ovf;
  bit held[512];
  int m_err;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [9:0] e;
    if (clrn && ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ev_unexpected: got %h, expected none", {ev_ext, ev_break, ev_code});
      end else begin
        e = exp_q.pop_front();
        if ({ev_ext, ev_break, ev_code} != e) begin
          errors++;
          $display("FAIL ev_data: got %h, expected %h", {ev_ext, ev_break, ev_code}, e);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    ev_ready = (rdy_mode == 2) || (rdy_mode == 0 && $urandom_range(0, 1) == 1);
  end

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_caps = 0; m_caps_held = 0; m_ovf = 0; m_err = 0;
    for (int i = 0; i < 512; i++) held[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      held[{m_ext, b}] = !m_brk;
      if (b == 8'h58) begin
        if (m_brk) m_caps_held = 0;
        else if (!m_caps_held) begin m_caps = !m_caps; m_caps_held = 1; end
      end
      if (rdy_mode == 1 && exp_q.size() >= DEPTH) m_ovf = 1;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  // bad: 0 good frame, 1 parity error, 2 stop error; lat checks ev_valid latency from the stop edge
  task automatic send_frame(input logic [7:0] b, input int bad, input bit lat);
    logic [10:0] f;
    f = {(bad != 2), (~^b) ^ (bad == 1), b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (lat && i == 10) begin
        repeat (4) @(posedge clk);
        #1 chk("lat_before", ev_valid, 0);
        @(posedge clk);
        #1 chk("lat_at", ev_valid, 1);
        repeat (HALF - 5) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
  endtask

  task automatic raw_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 ps2_data = (i != 0);
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int bad);
    if (bad != 0) begin
      if (m_err < 255) m_err++;
    end else begin
      model_byte(b);
    end
    send_frame(b, bad, 1'b0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_shift"}, mod_shift, held[9'h012] | held[9'h059]);
    chk({tag, "_ctrl"},  mod_ctrl,  held[9'h014] | held[9'h114]);
    chk({tag, "_alt"},   mod_alt,   held[9'h011] | held[9'h111]);
    chk({tag, "_caps"},  caps_lock, m_caps);
    chk({tag, "_err"},   err_cnt,   m_err);
    chk({tag, "_ovf"},   overflow,  m_ovf);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || ev_valid) && n < 3000) begin
      @(posedge clk); n++;
    end
    #1;
    chk({tag, "_drain_left"}, exp_q.size(), 0);
    chk({tag, "_drain_valid"}, ev_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, ev_valid, 0);
    chk({tag, "_level"}, ev_level, 0);
    chk({tag, "_mods"},  {mod_shift, mod_ctrl, mod_alt, caps_lock}, 0);
    chk({tag, "_ovf"},   overflow, 0);
    chk({tag, "_err"},   err_cnt, 0);
  endtask

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    model_reset();
    repeat (5) @(posedge clk);
    #1 check_reset_outputs("reset");
    clrn = 1'b1;
    repeat (5) @(posedge clk);

    // First event latency with the FIFO empty and the consumer stalled
    model_byte(8'h1C);
    send_frame(8'h1C, 0, 1'b1);
    chk("lat_level", ev_level, 1);
    rdy_mode = 2;
    wait_drain("lat");

    send(8'hF0, 0); send(8'h1C, 0);
    send(8'hE0, 0); send(8'h75, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    wait_drain("prefix");
    check_state("prefix");

    // Shift held across Caps auto-repeat
    send(8'h12, 0);
    check_state("shift_make");
    for (int i = 0; i < 3; i++) begin
      send(8'h58, 0);
      check_state("caps_make");
    end
    send(8'hF0, 0); send(8'h58, 0);
    send(8'hF0, 0); send(8'h12, 0);
    check_state("shift_brk");
    wait_drain("mods");

    send(8'h1C, 1);
    send(8'h1C, 0);
    send(8'h33, 2);
    check_state("badframe");
    wait_drain("badframe");

    // Overflow: stall consumer and overfill
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 10; i++) send(8'h15 + 8'(i), 0);
    chk("ovf_level", ev_level, DEPTH);
    check_state("ovf_set");
    rdy_mode = 2;
    wait_drain("ovf");
    chk("ovf_sticky", overflow, 1);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    m_ovf = 0;
    chk("ovf_clr", overflow, 0);

    // Randomised traffic with a random consumer
    rdy_mode = 0;
    for (int it = 0; it < 70; it++) begin
      r = $urandom_range(0, 99);
      if (r < 10) b = 8'hE0;
      else if (r < 24) b = 8'hF0;
      else if (r < 34) b = 8'h12;
      else if (r < 40) b = 8'h59;
      else if (r < 47) b = 8'h14;
      else if (r < 53) b = 8'h11;
      else if (r < 62) b = 8'h58;
      else b = 8'($urandom_range(1, 127));
      send(b, ($urandom_range(0, 19) == 0) ? 1 : 0);
      check_state("rand");
    end
    send(8'h2A, 0);
    rdy_mode = 2;
    wait_drain("rand");
    check_state("rand_end");

`ifdef PS2_TIMEOUT_EN
    raw_bits(5);
    repeat (TMO + 50) @(posedge clk);
    if (m_err < 255) m_err++;
    m_ext = 0; m_brk = 0;
    send(8'h1C, 0);
    wait_drain("timeout");
    check_state("timeout");
`endif

    // Reset mid-prefix and mid-frame
    send(8'hE0, 0);
    raw_bits(5);
    @(posedge clk); #1 clrn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("midreset");
    clrn = 1'b1;
    repeat (5) @(posedge clk);
    send(8'h75, 0);
    wait_drain("after_reset");
    check_state("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_events.md
# ps2_key_events

Parametrised PS/2 keyboard receiver that turns raw device frames into decoded key events. It deserialises 11-bit frames and tracks the E0 (extended) and F0 (break) prefixes itself. It keeps live modifier and Caps Lock state and buffers events in a FIFO of configurable depth behind a valid/ready handshake. It sits between the PS/2 pins and scancode-to-ASCII or application logic, so consumers see one complete event per key action and never handle prefix bytes.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of 2, minimum 2.
- `SYNC_STAGES`, 2: synchroniser flops on `ps2_clk` and `ps2_data`; minimum 2.
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles mid-frame before the frame is abandoned; used only with `PS2_TIMEOUT_EN`.

- `clk` in 1: system clock.
- `clrn` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: PS/2 clock pin, asynchronous.
- `ps2_data` in 1: PS/2 data pin, asynchronous.
- `ev_valid` out 1: FIFO non-empty.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_code` out 8: head event scancode, prefixes stripped.
- `ev_ext` out 1: head event was E0-prefixed.
- `ev_break` out 1: head event is a release.
- `ev_level` out $clog2(FIFO_DEPTH)+1: FIFO fill count.
- `mod_shift`, `mod_ctrl`, `mod_alt` out 1 each: the key is currently held.
- `caps_lock` out 1: Caps Lock toggle state.
- `overflow` out 1: sticky flag, set when an event was dropped.
- `ovf_clr` in 1: synchronous clear of `overflow`.
- `err_cnt` out 8: saturating count of bad frames.

## Operation
- **Reset values:** all outputs 0, FIFO empty, decoder in IDLE, bit counter 0, `caps_held` 0.
- **Edge detection:** the synchronised `ps2_clk` is watched for a falling edge, which raises a one-cycle `sample` strobe.
- **Deserialiser:**
  - Bit counter runs 0..10; the synchronised data is captured on each `sample`.
  - At bit 10 the frame is checked: start=0, stop=1, odd parity over data plus parity bit.
  - Good frame: byte is passed to the decoder.
  - Bad frame: byte is dropped and `err_cnt` increments, saturating at 255.
  - The counter returns to 0 either way.
- **Decoder FSM:** states IDLE, EXT, BRK, EXT_BRK.
  - E0: goes to EXT from any state; a prefix always resynchronises.
  - F0: IDLE→BRK, EXT→EXT_BRK; stays put in BRK or EXT_BRK.
  - Any other byte: emits `{ext,brk,code}` (ext=1 in EXT/EXT_BRK, brk=1 in BRK/EXT_BRK), then returns to IDLE.
- **Modifiers:** updated from each emitted event, on the same edge as the FIFO write.
  - `mod_shift` tracks codes 12 or 59 (non-ext); both are tracked separately and ORed.
  - `mod_ctrl` tracks 14 (ext or not), left and right ORed.
  - `mod_alt` tracks 11 (ext or not), ORed.
  - A make sets the key's held bit; a break clears it.
- **Caps Lock:**
  - A make of 58 with `caps_held`=0 toggles `caps_lock` and sets `caps_held`.
  - Auto-repeat makes are ignored for the toggle.
  - A break of 58 clears `caps_held`.
  - Modifier and Caps events are still queued.
- **FIFO:** first-word fall-through; head is shown on `ev_*`.
  - Pop when `ev_valid && ev_ready`.
  - Push when an event is emitted and the FIFO is not full, or is full with a pop in the same cycle.
  - Otherwise the event is dropped and `overflow` is set.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - If `ovf_clr` and a new drop occur in the same cycle, set wins.

## Timing
- Let cycle S be the `sample` cycle of the stop bit.
  - Frame check result is registered at S+1.
  - Event is written, and modifiers update, at the edge ending S+1.
  - `ev_valid`=1 in S+2 if the FIFO was empty.
- Pin-to-`sample` delay is SYNC_STAGES+1 cycles.
- Prefix bytes produce no event; their only effect is the FSM state at S+2.
- A pop takes effect at the clock edge. The next entry, or `ev_valid`=0, appears the following cycle. Data stays stable while `ev_valid && !ev_ready`.
- Sustained push plus pop with the FIFO full leaves `ev_level` unchanged and causes no drop.
- `clrn` asserted mid-frame or mid-prefix: everything returns to reset values immediately. The partial frame is lost, and `err_cnt` does not count it.

## Configuration
- `PS2_TIMEOUT_EN` defined:
  - An idle counter runs while the bit counter is nonzero and is cleared on each `sample`.
  - At TIMEOUT_CYCLES: bit counter→0, decoder→IDLE, `err_cnt` increments by 1.
- Undefined: no watchdog. A lost bit misaligns framing until a parity or stop error occurs.

## Test plan
- Frame 1C, then F0 1C, with `ev_ready`=1 → two events: {0,0,1C} then {0,1,1C}. `err_cnt`=0.
- E0 75, E0 F0 75 → {1,0,75} then {1,1,75}. No events are emitted for the prefixes.
- 12 make, 58 make ×3 (repeat), 58 break, 12 break → `mod_shift` rises then falls. `caps_lock`=1 after the first 58 only; six events queued.
- `ev_ready`=0, FIFO_DEPTH=8, 10 make codes → `ev_level`=8, `overflow`=1. Draining yields the first 8 codes in order. `ovf_clr` then clears the flag.
- Frame with wrong parity, then a valid 1C → `err_cnt`=1, only {0,0,1C} emitted.
- With `PS2_TIMEOUT_EN`: 5 bits, then idle for TIMEOUT_CYCLES, then a full frame 1C → `err_cnt`=1, {0,0,1C} emitted. Without the macro the same stimulus yields no correct event.
